// File: rtl/ame_num_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ame_num_pkg
//  Description : Shared types, operand indices and the saturation helper
//                for the AME numerator compute pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package ame_num_pkg;

    // Operand positions inside one lane's input word
    localparam int IDX_M = 3;
    localparam int IDX_D = 2;
    localparam int IDX_L = 1;
    localparam int IDX_C = 0;

    // Widest extended operand supported (DATA_BITS up to 64, plus one extension bit)
    localparam int OPND_MAX_BITS = 65;
    // Saturation working width; always at least 2 bits wider than any difference
    localparam int SAT_W = 2 * OPND_MAX_BITS + 2;
    localparam logic signed [SAT_W-1:0] SAT_ONE = SAT_W'(1);

    // Extended operands of one lane, stored at the maximum supported width
    typedef struct packed {
        logic [OPND_MAX_BITS-1:0] m;
        logic [OPND_MAX_BITS-1:0] d;
        logic [OPND_MAX_BITS-1:0] l;
        logic [OPND_MAX_BITS-1:0] c;
    } ame_num_ops_t;

    // Clamp a signed value to out_bits; returns {ovf, clamped value}
    function automatic logic [SAT_W:0] sat_signed(input logic signed [SAT_W-1:0] value,
                                                  input int                      out_bits);
        logic signed [SAT_W-1:0] v_max;
        logic signed [SAT_W-1:0] v_min;
        v_max = (SAT_ONE <<< (out_bits - 1)) - SAT_ONE;
        v_min = -v_max - SAT_ONE;
        if (value > v_max) begin
            return {1'b1, v_max};
        end else if (value < v_min) begin
            return {1'b1, v_min};
        end else begin
            return {1'b0, value};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/ame_num_compute_pipe_lane.sv
`default_nettype none
// ============================================================================
//  Module      : ame_num_lane
//  Description : One lane of R = M*D - L*C: extend, multiply, subtract,
//                saturate, optional delay. Stage loads come from the top.
//  Revision    : 1.0 - initial release
// ============================================================================
module ame_num_lane
    import ame_num_pkg::*;
#(
    parameter int DATA_BITS   = 32,
    parameter int OUT_BITS    = 65,
    parameter int PIPE_STAGES = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [PIPE_STAGES-1:0]     i_ld,
    input  logic                       i_signed,
    input  logic [3:0][DATA_BITS-1:0]  i_ops,
    output logic [OUT_BITS-1:0]        o_data,
    output logic                       o_ovf
);
    localparam int EXT_W  = DATA_BITS + 1;
    localparam int PROD_W = 2 * DATA_BITS + 2;

    ame_num_ops_t               w_ext;
    ame_num_ops_t               r_op;
    logic signed [PROD_W-1:0]   w_m, w_d, w_l, w_c;
    logic signed [PROD_W-1:0]   r_p1, r_p2;
    logic signed [PROD_W-1:0]   w_diff;
    logic [SAT_W:0]             w_sat_full;
    logic                       w_unused;

    // Sign- or zero-extend a raw operand depending on the transaction mode
    function automatic logic [OPND_MAX_BITS-1:0] ext_op(input logic [DATA_BITS-1:0] v,
                                                        input logic                 sgn);
        return {{(OPND_MAX_BITS-DATA_BITS){sgn & v[DATA_BITS-1]}}, v};
    endfunction

    // Bring a (W+1)-bit extended operand up to product width
    function automatic logic signed [PROD_W-1:0] to_prod(input logic [OPND_MAX_BITS-1:0] f);
        return {{(PROD_W-EXT_W){f[EXT_W-1]}}, f[EXT_W-1:0]};
    endfunction

    // Operand extension; the mode is folded into the stored operands
    always_comb begin
        w_ext   = '0;
        w_ext.m = ext_op(i_ops[IDX_M], i_signed);
        w_ext.d = ext_op(i_ops[IDX_D], i_signed);
        w_ext.l = ext_op(i_ops[IDX_L], i_signed);
        w_ext.c = ext_op(i_ops[IDX_C], i_signed);
    end

    // Stage 1: capture extended operands
    always_ff @(posedge clk_i) begin
        if (i_ld[0]) r_op <= w_ext;
    end

    assign w_m = to_prod(r_op.m);
    assign w_d = to_prod(r_op.d);
    assign w_l = to_prod(r_op.l);
    assign w_c = to_prod(r_op.c);

    // Stage 2: both products at full signed width
    always_ff @(posedge clk_i) begin
        if (i_ld[1]) begin
            r_p1 <= w_m * w_d;
            r_p2 <= w_l * w_c;
        end
    end

    assign w_diff     = r_p1 - r_p2;
    assign w_sat_full = sat_signed({{(SAT_W-PROD_W){w_diff[PROD_W-1]}}, w_diff}, OUT_BITS);
    // Upper saturation bits and unused operand bits are redundant sign copies
    assign w_unused   = ^{r_op, w_sat_full};

    // Stage 3 holds the saturated result; later stages are pure delay.
    // Only the final stage is the output register and is reset.
    for (genvar k = 3; k <= PIPE_STAGES; k++) begin : g_stage
        logic [OUT_BITS-1:0] r_res;
        logic                r_ovf;
        logic [OUT_BITS-1:0] w_res_d;
        logic                w_ovf_d;

        if (k == 3) begin : g_first
            assign w_res_d = w_sat_full[OUT_BITS-1:0];
            assign w_ovf_d = w_sat_full[SAT_W];
        end else begin : g_dly
            assign w_res_d = g_stage[k-1].r_res;
            assign w_ovf_d = g_stage[k-1].r_ovf;
        end

        if (k == PIPE_STAGES) begin : g_out
            // Output register: cleared by reset so no stale result is visible
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_res <= '0;
                    r_ovf <= 1'b0;
                end else if (i_ld[k-1]) begin
                    r_res <= w_res_d;
                    r_ovf <= w_ovf_d;
                end
            end
        end else begin : g_mid
            // Intermediate datapath stage, no reset needed
            always_ff @(posedge clk_i) begin
                if (i_ld[k-1]) begin
                    r_res <= w_res_d;
                    r_ovf <= w_ovf_d;
                end
            end
        end
    end

    assign o_data = g_stage[PIPE_STAGES].r_res;
    assign o_ovf  = g_stage[PIPE_STAGES].r_ovf;

endmodule
`default_nettype wire

// File: rtl/ame_num_compute_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ame_num_compute_pipe
//  Description : Multi-lane pipelined AME numerator R = M*D - L*C with
//                bubble-collapsing valid/ready stages and optional saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module ame_num_compute_pipe
    import ame_num_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int DATA_BITS   = 32,
    parameter int OUT_BITS    = 65,
    parameter int PIPE_STAGES = 3
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  comp_valid_i,
    output logic                                  comp_ready_o,
    input  logic                                  comp_signed_i,
    input  logic [LANES-1:0][3:0][DATA_BITS-1:0]  comp_data_i,
    output logic                                  comp_valid_o,
    input  logic                                  comp_ready_i,
    output logic [LANES-1:0][OUT_BITS-1:0]        comp_data_o,
    output logic [LANES-1:0]                      comp_ovf_o,
    output logic                                  comp_busy_o
);
    logic [PIPE_STAGES-1:0] r_v;
    logic [PIPE_STAGES-1:0] w_adv;
    logic [PIPE_STAGES-1:0] w_ld;

    // Advance chain: a stage moves forward when the next one is empty or moving
    always_comb begin
        w_adv                = '0;
        w_adv[PIPE_STAGES-1] = r_v[PIPE_STAGES-1] & comp_ready_i;
        for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
            w_adv[k] = r_v[k] & (~r_v[k+1] | w_adv[k+1]);
        end
    end

    // Ready is combinational from comp_ready_i and held low during reset
    assign comp_ready_o = ~rst_i & (~r_v[0] | w_adv[0]);

    // Stage load enables: stage 1 on input accept, stage k+1 when stage k advances
    always_comb begin
        w_ld    = '0;
        w_ld[0] = comp_valid_i & comp_ready_o;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            w_ld[k] = w_adv[k-1];
        end
    end

    // Stage valid bits: set on load, cleared when the occupant leaves without refill
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (w_ld[k])       r_v[k] <= 1'b1;
                else if (w_adv[k]) r_v[k] <= 1'b0;
            end
        end
    end

    assign comp_valid_o = r_v[PIPE_STAGES-1];
    assign comp_busy_o  = |r_v;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ame_num_lane #(
            .DATA_BITS   (DATA_BITS),
            .OUT_BITS    (OUT_BITS),
            .PIPE_STAGES (PIPE_STAGES)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .i_ld     (w_ld),
            .i_signed (comp_signed_i),
            .i_ops    (comp_data_i[g]),
            .o_data   (comp_data_o[g]),
            .o_ovf    (comp_ovf_o[g])
        );
    end

endmodule
`default_nettype wire
